motion_vector_comparator: RTL

- Downstream consumer of the accumulator processing elements in the motion estimator.
- Receives one saturated 8-bit distance per candidate search position, in raster order, as each processing element finishes its block.
- Tracks the minimum distance and the position where it occurred.
- When the search window completes, reports the best distance and the motion vector (x, y), then returns to idle.

---
 rtl/motion_vector_comparator_if.sv | 27 ++
 rtl/motion_vector_comparator.sv | 123 ++++++++++++
 2 files changed

// File: rtl/motion_vector_comparator_if.sv
// Bundle of signals between the distance producer and the motion-vector
// comparator: search start, per-candidate distance stream, and results.
interface motion_vector_comparator_if #(
    parameter int DIST_W = 8,
    parameter int MV_W   = 4
);
    logic              start;
    logic              dist_valid;
    logic [DIST_W-1:0] dist_in;
    logic              busy;
    logic              done;
    logic [DIST_W-1:0] best_dist;
    logic [MV_W-1:0]   motion_x;
    logic [MV_W-1:0]   motion_y;

    // Producer side: launches a search and streams candidate distances.
    modport master (
        output start, dist_valid, dist_in,
        input  busy, done, best_dist, motion_x, motion_y
    );

    // Comparator side: consumes distances and reports the best match.
    modport slave (
        input  start, dist_valid, dist_in,
        output busy, done, best_dist, motion_x, motion_y
    );
endinterface

// File: rtl/motion_vector_comparator.sv
// Motion-vector comparator: scans one distance per candidate position in
// raster order, keeps the smallest (earliest on ties) and reports it with
// its (column, row) position when the whole search window has been seen.
module motion_vector_comparator #(
    parameter int DIST_W   = 8,
    parameter int SRCH_DIM = 16,
    parameter int MV_W     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    motion_vector_comparator_if.slave   bus
);
    localparam int NUM_CAND = SRCH_DIM * SRCH_DIM;
    localparam int CNT_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    localparam logic [CNT_W-1:0]  LAST_K   = CNT_W'(NUM_CAND - 1);
    localparam logic [MV_W-1:0]   LAST_COL = MV_W'(SRCH_DIM - 1);
    localparam logic [DIST_W-1:0] DIST_SAT = {DIST_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cand_r, cand_s;
    logic [MV_W-1:0]   col_r, col_s;
    logic [MV_W-1:0]   row_r, row_s;
    logic [DIST_W-1:0] best_r, best_s;
    logic [MV_W-1:0]   mx_r, mx_s;
    logic [MV_W-1:0]   my_r, my_s;
    logic              busy_r, done_r;

    // Next-state and datapath update: preload on start, compare on each valid.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        col_s   = col_r;
        row_s   = row_r;
        best_s  = best_r;
        mx_s    = mx_r;
        my_s    = my_r;
        case (state_r)
            IDLE: begin
                cand_s = '0;
                col_s  = '0;
                row_s  = '0;
                if (bus.start) begin
                    state_s = SEARCH;
                    best_s  = DIST_SAT;
                    mx_s    = '0;
                    my_s    = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
                if (bus.dist_valid) begin
                    // First candidate always loads so a saturated window reports (0,0).
                    if ((cand_r == '0) || (bus.dist_in < best_r)) begin
                        best_s = bus.dist_in;
                        mx_s   = col_r;
                        my_s   = row_r;
                    end else begin
                        best_s = best_r;
                    end
                    if (cand_r == LAST_K) begin
                        state_s = DONE;
                    end else begin
                        state_s = SEARCH;
                        cand_s  = cand_r + CNT_W'(1);
                        if (col_r == LAST_COL) begin
                            col_s = '0;
                            row_s = row_r + MV_W'(1);
                        end else begin
                            col_s = col_r + MV_W'(1);
                        end
                    end
                end else begin
                    state_s = SEARCH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; synchronous reset aborts any search.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cand_r  <= '0;
            col_r   <= '0;
            row_r   <= '0;
            best_r  <= DIST_SAT;
            mx_r    <= '0;
            my_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cand_r  <= cand_s;
            col_r   <= col_s;
            row_r   <= row_s;
            best_r  <= best_s;
            mx_r    <= mx_s;
            my_r    <= my_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.best_dist = best_r;
    assign bus.motion_x  = mx_r;
    assign bus.motion_y  = my_r;
endmodule
